// File: rtl/reg_file_sequencer.sv
// Register-file bus initiator: accepts READ/WRITE/MOVE/SWAP commands, sequences the register
// file control pins and returns results. Define REG_FILE_SEQ_FAST_MOVE_EN for single-cycle MOVE.
module reg_file_sequencer #(
    parameter int WORD_SIZE = 32,
    parameter int SEL_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [SEL_WIDTH-1:0] cmd_sel_a,
    input  logic [SEL_WIDTH-1:0] cmd_sel_b,
    input  logic [WORD_SIZE-1:0] cmd_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_a,
    output logic [WORD_SIZE-1:0] rsp_b,
    output logic                 rsp_err,
    output logic                 oe_a,
    output logic                 oe_b,
    output logic                 ld,
    output logic [SEL_WIDTH-1:0] sel_a,
    output logic [SEL_WIDTH-1:0] sel_b,
    output logic [WORD_SIZE-1:0] input_bus,
    input  logic [WORD_SIZE-1:0] a_bus,
    input  logic [WORD_SIZE-1:0] b_bus
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        RD      = 4'd1,
        WR      = 4'd2,
        MV_RD   = 4'd3,
        MV_WR   = 4'd4,
        SW_RD   = 4'd5,
        SW_WR_X = 4'd6,
        SW_WR_Y = 4'd7,
        RSP     = 4'd8,
        MV      = 4'd9
    } state_t;

    localparam logic [1:0]           OP_READ  = 2'd0;
    localparam logic [1:0]           OP_WRITE = 2'd1;
    localparam logic [1:0]           OP_MOVE  = 2'd2;
    localparam logic [1:0]           OP_SWAP  = 2'd3;
    localparam logic [SEL_WIDTH-1:0] SEL_BAD  = {SEL_WIDTH{1'b1}};

    state_t                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   xa_q, xa_d, xb_q, xb_d;
    logic [WORD_SIZE-1:0]   rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   oe_a_q, oe_a_d, oe_b_q, oe_b_d, ld_q, ld_d;
    logic [SEL_WIDTH-1:0]   sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic [WORD_SIZE-1:0]   input_bus_q, input_bus_d;
    logic                   bad_sel_s;

    // rsp_a/rsp_b double as the MOVE temp and the SWAP tx/ty holding registers.
    // Pin values are computed from the next state so every control line is a flop.
    // Next-state, latched-field and registered-output computation.
    always_comb begin
        state_d     = state_q;
        xa_d        = xa_q;
        xb_d        = xb_q;
        rsp_a_d     = rsp_a_q;
        rsp_b_d     = rsp_b_q;
        rsp_err_d   = rsp_err_q;
        oe_a_d      = 1'b0;
        oe_b_d      = 1'b0;
        ld_d        = 1'b0;
        sel_a_d     = {SEL_WIDTH{1'b0}};
        sel_b_d     = {SEL_WIDTH{1'b0}};
        input_bus_d = {WORD_SIZE{1'b0}};
        bad_sel_s   = (cmd_sel_a == SEL_BAD) || ((cmd_op != OP_WRITE) && (cmd_sel_b == SEL_BAD));

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    xa_d      = cmd_sel_a;
                    xb_d      = cmd_sel_b;
                    rsp_a_d   = {WORD_SIZE{1'b0}};
                    rsp_b_d   = {WORD_SIZE{1'b0}};
                    rsp_err_d = 1'b0;
                    if (bad_sel_s) begin
                        state_d   = RSP;
                        rsp_err_d = 1'b1;
                    end else begin
                        case (cmd_op)
                            OP_READ:  state_d = RD;
                            OP_WRITE: begin
                                state_d = WR;
                                rsp_a_d = cmd_data;
                            end
`ifdef REG_FILE_SEQ_FAST_MOVE_EN
                            OP_MOVE:  state_d = MV;
`else
                            OP_MOVE:  state_d = MV_RD;
`endif
                            OP_SWAP:  state_d = SW_RD;
                            default:  state_d = IDLE;
                        endcase
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                state_d = RSP;
                rsp_a_d = a_bus;
                rsp_b_d = b_bus;
            end
            WR:      state_d = RSP;
            MV_RD: begin
                state_d = MV_WR;
                rsp_a_d = b_bus;
            end
            MV_WR:   state_d = RSP;
`ifdef REG_FILE_SEQ_FAST_MOVE_EN
            MV: begin
                state_d = RSP;
                rsp_a_d = b_bus;
            end
`endif
            SW_RD: begin
                state_d = SW_WR_X;
                rsp_a_d = a_bus;
                rsp_b_d = b_bus;
            end
            SW_WR_X: state_d = SW_WR_Y;
            SW_WR_Y: state_d = RSP;
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RSP;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            RD, SW_RD: begin
                oe_a_d  = 1'b1;
                oe_b_d  = 1'b1;
                sel_a_d = xa_d;
                sel_b_d = xb_d;
            end
            WR: begin
                ld_d        = 1'b1;
                sel_a_d     = xa_d;
                input_bus_d = rsp_a_d;
            end
            MV_RD: begin
                oe_b_d  = 1'b1;
                sel_b_d = xb_d;
            end
            MV_WR: begin
                ld_d        = 1'b1;
                sel_a_d     = xa_d;
                input_bus_d = rsp_a_d;
            end
            MV: begin
                oe_b_d  = 1'b1;
                ld_d    = 1'b1;
                sel_a_d = xa_d;
                sel_b_d = xb_d;
            end
            SW_WR_X: begin
                ld_d        = 1'b1;
                sel_a_d     = xa_d;
                input_bus_d = rsp_b_d;
            end
            SW_WR_Y: begin
                ld_d        = 1'b1;
                sel_a_d     = xb_d;
                input_bus_d = rsp_a_d;
            end
            default: begin
                oe_a_d = 1'b0;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RSP);
    end

    // State, latched command fields and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            xa_q        <= {SEL_WIDTH{1'b0}};
            xb_q        <= {SEL_WIDTH{1'b0}};
            rsp_a_q     <= {WORD_SIZE{1'b0}};
            rsp_b_q     <= {WORD_SIZE{1'b0}};
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            oe_a_q      <= 1'b0;
            oe_b_q      <= 1'b0;
            ld_q        <= 1'b0;
            sel_a_q     <= {SEL_WIDTH{1'b0}};
            sel_b_q     <= {SEL_WIDTH{1'b0}};
            input_bus_q <= {WORD_SIZE{1'b0}};
        end else begin
            state_q     <= state_d;
            xa_q        <= xa_d;
            xb_q        <= xb_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            oe_a_q      <= oe_a_d;
            oe_b_q      <= oe_b_d;
            ld_q        <= ld_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            input_bus_q <= input_bus_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_a     = rsp_a_q;
    assign rsp_b     = rsp_b_q;
    assign rsp_err   = rsp_err_q;
    assign oe_a      = oe_a_q;
    assign oe_b      = oe_b_q;
    assign ld        = ld_q;
    assign sel_a     = sel_a_q;
    assign sel_b     = sel_b_q;
`ifdef REG_FILE_SEQ_FAST_MOVE_EN
    // Fast MOVE forwards the source register straight onto the write bus.
    assign input_bus = (state_q == MV) ? b_bus : input_bus_q;
`else
    assign input_bus = input_bus_q;
`endif

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Directed bench for reg_file_sequencer with a behavioural register file on its pins.
module tb_reg_file_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_sel_a = 8'd0;
    logic [7:0]  cmd_sel_b = 8'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_a, rsp_b;
    logic        rsp_err;
    logic        oe_a, oe_b, ld;
    logic [7:0]  sel_a, sel_b;
    logic [31:0] input_bus, a_bus, b_bus;

    logic [31:0] regs [256];
    int nchk = 0;
    int nfail = 0;
    int ld_cnt = 0;
    int oe_cnt = 0;
    int ovl_cnt = 0;
    int ibad_cnt = 0;

`ifdef REG_FILE_SEQ_FAST_MOVE_EN
    localparam int MV_LAT = 2;
`else
    localparam int MV_LAT = 3;
`endif

    reg_file_sequencer #(.WORD_SIZE(32), .SEL_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_sel_a(cmd_sel_a), .cmd_sel_b(cmd_sel_b), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_err(rsp_err),
        .oe_a(oe_a), .oe_b(oe_b), .ld(ld), .sel_a(sel_a), .sel_b(sel_b),
        .input_bus(input_bus), .a_bus(a_bus), .b_bus(b_bus)
    );

    always #5 clk = ~clk;

    assign a_bus = oe_a ? regs[sel_a] : 32'd0;
    assign b_bus = oe_b ? regs[sel_b] : 32'd0;

    always @(posedge clk) begin
        if (ld) begin
            regs[sel_a] <= input_bus;
            ld_cnt      <= ld_cnt + 1;
        end
        if (oe_a || oe_b) oe_cnt <= oe_cnt + 1;
    end

    always @(negedge clk) begin
        if (ld && oe_a) ovl_cnt <= ovl_cnt + 1;
`ifndef REG_FILE_SEQ_FAST_MOVE_EN
        if (ld && oe_b) ovl_cnt <= ovl_cnt + 1;
`endif
        if (!ld && input_bus != 32'd0) ibad_cnt <= ibad_cnt + 1;
    end

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  sa;
        logic [7:0]  sb;
        logic [31:0] data;
        int          dly;
        int          lat;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        eerr;
        int          eld;
        int          eoe;
    } vec_t;

    vec_t tv[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] sa, input logic [7:0] sb,
                        input logic [31:0] d);
        int n = 0;
        cmd_op = op; cmd_sel_a = sa; cmd_sel_b = sb; cmd_data = d; cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic collect(input string nm, input int dly, input int lat_e,
                           input logic [31:0] ea, input logic [31:0] eb, input logic eerr);
        int lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, lat, lat_e);
        chk({nm, "_rsp_a"}, rsp_a, ea);
        chk({nm, "_rsp_b"}, rsp_b, eb);
        chk({nm, "_rsp_err"}, {31'd0, rsp_err}, {31'd0, eerr});
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({nm, "_hold_rsp_a"}, rsp_a, ea);
            chk({nm, "_hold_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        int ld0, oe0;
        for (int i = 0; i < 256; i++) regs[i] <= 32'd0;
        regs[0] <= 32'h1;
        regs[1] <= 32'hAAAA;
        regs[2] <= 32'h5555;
        regs[3] <= 32'h333;

        //          op     sa     sb     data           dly lat     ea             eb             err   ld oe
        tv[0]  = '{2'd1, 8'd5,   8'd0,   32'hDEADBEEF, 0, 2,      32'hDEADBEEF, 32'd0,        1'b0, 1, 0};
        tv[1]  = '{2'd0, 8'd5,   8'd0,   32'd0,        2, 2,      32'hDEADBEEF, 32'h1,        1'b0, 0, 1};
        tv[2]  = '{2'd1, 8'd5,   8'd0,   32'h12345678, 0, 2,      32'h12345678, 32'd0,        1'b0, 1, 0};
        tv[3]  = '{2'd2, 8'd7,   8'd5,   32'd0,        0, MV_LAT, 32'h12345678, 32'd0,        1'b0, 1, 1};
        tv[4]  = '{2'd0, 8'd7,   8'd5,   32'd0,        0, 2,      32'h12345678, 32'h12345678, 1'b0, 0, 1};
        tv[5]  = '{2'd3, 8'd1,   8'd2,   32'd0,        0, 4,      32'hAAAA,     32'h5555,     1'b0, 2, 1};
        tv[6]  = '{2'd0, 8'd1,   8'd2,   32'd0,        0, 2,      32'h5555,     32'hAAAA,     1'b0, 0, 1};
        tv[7]  = '{2'd3, 8'd3,   8'd3,   32'd0,        0, 4,      32'h333,      32'h333,      1'b0, 2, 1};
        tv[8]  = '{2'd0, 8'd3,   8'd3,   32'd0,        0, 2,      32'h333,      32'h333,      1'b0, 0, 1};
        tv[9]  = '{2'd0, 8'hFF,  8'd0,   32'd0,        0, 1,      32'd0,        32'd0,        1'b1, 0, 0};
        tv[10] = '{2'd1, 8'hFF,  8'd0,   32'h77,       0, 1,      32'd0,        32'd0,        1'b1, 0, 0};
        tv[11] = '{2'd2, 8'd4,   8'hFF,  32'd0,        0, 1,      32'd0,        32'd0,        1'b1, 0, 0};
        tv[12] = '{2'd3, 8'hFF,  8'hFF,  32'd0,        0, 1,      32'd0,        32'd0,        1'b1, 0, 0};
        tv[13] = '{2'd1, 8'hFE,  8'hFF,  32'hCAFE0001, 0, 2,      32'hCAFE0001, 32'd0,        1'b0, 1, 0};
        tv[14] = '{2'd0, 8'hFE,  8'd0,   32'd0,        0, 2,      32'hCAFE0001, 32'h1,        1'b0, 0, 1};

        // reset values
        #2;
        chk("reset_outputs", {26'd0, cmd_ready, rsp_valid, rsp_err, oe_a, oe_b, ld}, 32'd0);
        chk("reset_rsp_a", rsp_a, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_before_clock", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1 chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            ld0 = ld_cnt;
            oe0 = oe_cnt;
            send(tv[i].op, tv[i].sa, tv[i].sb, tv[i].data);
            collect($sformatf("vec%0d", i), tv[i].dly, tv[i].lat, tv[i].ea, tv[i].eb, tv[i].eerr);
            chk($sformatf("vec%0d_ld_pulses", i), ld_cnt - ld0, tv[i].eld);
            chk($sformatf("vec%0d_oe_cycles", i), oe_cnt - oe0, tv[i].eoe);
        end
        chk("move_dest_r7", regs[7], 32'h12345678);
        chk("write_r254", regs[254], 32'hCAFE0001);

        // backpressure with the next command waiting
        send(2'd0, 8'd5, 8'd0, 32'd0);
        cmd_op = 2'd0; cmd_sel_a = 8'd1; cmd_sel_b = 8'd2; cmd_valid = 1'b1;
        collect("bp_read", 5, 2, 32'h12345678, 32'h1, 1'b0);
        chk("bp_valid_fell", {31'd0, rsp_valid}, 32'd0);
        chk("bp_ready_back", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        collect("bp_next", 0, 2, 32'h5555, 32'hAAAA, 1'b0);

        // reset while the second SWAP write is on the bus
        send(2'd3, 8'd1, 8'd2, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("sw_wr_y_ld", {31'd0, ld}, 32'd1);
        chk("sw_wr_y_sel", {24'd0, sel_a}, 32'd2);
        chk("sw_wr_y_bus", input_bus, 32'h5555);
        ld0 = ld_cnt;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", {27'd0, oe_a, oe_b, ld, rsp_valid, cmd_ready}, 32'd0);
        chk("half_swap_r1", regs[1], 32'hAAAA);
        chk("half_swap_r2", regs[2], 32'hAAAA);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rst_ready_after", {31'd0, cmd_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_ld", ld_cnt - ld0, 32'd0);
        chk("rst_r2_kept", regs[2], 32'hAAAA);

        chk("ld_oe_overlap", ovl_cnt, 32'd0);
        chk("input_bus_idle_zero", ibad_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
